// File: rtl/video_modes_pkg.sv
// Video mode definitions shared by the timing generator and its consumers.
// Provides the per-mode timing record, the 4-entry mode table, coordinate
// widths and helpers that derive line/frame totals.
package video_modes_pkg;

  localparam int unsigned BEAM_X_W  = 12;
  localparam int unsigned BEAM_Y_W  = 11;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned NUM_MODES = 4;
  localparam int unsigned SYNC_W    = 3;  // {hsync, vsync, blank}

  typedef logic [BEAM_X_W-1:0] hcoord_t;
  typedef logic [BEAM_Y_W-1:0] vcoord_t;
  typedef logic [MODE_W-1:0]   mode_idx_t;

  typedef struct packed {
    hcoord_t h_res;
    hcoord_t h_fp;
    hcoord_t h_sp;
    hcoord_t h_bp;
    vcoord_t v_res;
    vcoord_t v_fp;
    vcoord_t v_sp;
    vcoord_t v_bp;
    logic    pos_pol;  // 1 = syncs are active high
  } mode_t;

  localparam mode_t MODE_TABLE [NUM_MODES] = '{
    '{12'd640,  12'd16,  12'd96,  12'd48,  11'd480,  11'd10, 11'd2, 11'd33, 1'b0},
    '{12'd1280, 12'd110, 12'd40,  12'd220, 11'd720,  11'd5,  11'd5, 11'd20, 1'b1},
    '{12'd1920, 12'd88,  12'd44,  12'd148, 11'd1080, 11'd4,  11'd5, 11'd36, 1'b1},
    '{12'd800,  12'd40,  12'd128, 12'd88,  11'd600,  11'd1,  11'd4, 11'd23, 1'b1}
  };

  function automatic hcoord_t h_total(input mode_t c);
    return c.h_res + c.h_fp + c.h_sp + c.h_bp;
  endfunction

  function automatic vcoord_t v_total(input mode_t c);
    return c.v_res + c.v_fp + c.v_sp + c.v_bp;
  endfunction

endpackage

// File: rtl/video_timing_multi_if.sv
// Bundle between the timing generator (master) and its pixel source / encoder
// (slave). Controls: enable, mode_sel. Results: mode_cur, beam_x/beam_y,
// frame_start, delayed vga_hsync/vga_vsync/vga_blank.
interface video_timing_multi_if;
  import video_modes_pkg::*;

  logic      enable;
  mode_idx_t mode_sel;
  mode_idx_t mode_cur;
  hcoord_t   beam_x;
  vcoord_t   beam_y;
  logic      frame_start;
  logic      vga_hsync;
  logic      vga_vsync;
  logic      vga_blank;

  modport master (
    input  enable, mode_sel,
    output mode_cur, beam_x, beam_y, frame_start, vga_hsync, vga_vsync, vga_blank
  );

  modport slave (
    output enable, mode_sel,
    input  mode_cur, beam_x, beam_y, frame_start, vga_hsync, vga_vsync, vga_blank
  );
endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth register pipeline for sync/blank alignment.
// Ports: clk, rst_n (async active-low), rst_value (value every stage takes
// in reset), d (input sample), q (sample from DEPTH cycles ago; d when DEPTH=0).
module sync_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_value,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift register; stage 0 takes the newest sample
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= rst_value;
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_multi.sv
// Multi-mode video timing generator: beam counters, frame-boundary mode
// latch, sync/blank decode and a C_delay-deep alignment pipeline.
// Ports: clk_pixel, resetn (async active-low), vid (master modport:
// enable/mode_sel in; mode_cur, beam_x/y, frame_start, vga_* out).
module video_timing_multi
  import video_modes_pkg::*;
#(
  parameter int unsigned C_delay        = 2,
  parameter mode_idx_t   C_default_mode = 2'd2
) (
  input  logic                clk_pixel,
  input  logic                resetn,
  video_timing_multi_if.master vid
);

  hcoord_t   x_q, x_n;
  vcoord_t   y_q, y_n;
  mode_idx_t mode_q, mode_n;
  logic      run_q, run_n;   // counting was enabled on the previous edge
  logic      fs_q, fs_n;

  mode_t   cfg;
  hcoord_t h_last;
  vcoord_t v_last;

  assign cfg    = MODE_TABLE[mode_q];
  assign h_last = h_total(cfg) - hcoord_t'(1);
  assign v_last = v_total(cfg) - vcoord_t'(1);

  // State register
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= C_default_mode;
      run_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_n;
      y_q    <= y_n;
      mode_q <= mode_n;
      run_q  <= run_n;
      fs_q   <= fs_n;
    end
  end

  // Next state: the first enabled edge after a hold re-presents (0,0) as a
  // new frame instead of stepping past it
  always_comb begin
    x_n    = x_q;
    y_n    = y_q;
    mode_n = mode_q;
    run_n  = run_q;
    fs_n   = 1'b0;
    if (!vid.enable) begin
      x_n    = '0;
      y_n    = '0;
      run_n  = 1'b0;
      mode_n = vid.mode_sel;
    end else if (!run_q) begin
      x_n   = '0;
      y_n   = '0;
      run_n = 1'b1;
      fs_n  = 1'b1;
    end else if (x_q == h_last) begin
      x_n = '0;
      if (y_q == v_last) begin
        y_n    = '0;
        mode_n = vid.mode_sel;
        fs_n   = 1'b1;
      end else begin
        y_n = y_q + vcoord_t'(1);
      end
    end else begin
      x_n = x_q + hcoord_t'(1);
    end
  end

  // Sync/blank decode of the current beam, polarity applied with this
  // cycle's mode so straddling frames stay consistent through the delay
  logic              gate, visible, h_act, v_act;
  hcoord_t           hs_start, hs_end;
  vcoord_t           vs_start, vs_end;
  logic [SYNC_W-1:0] sample_c, delayed;

  always_comb begin
    hs_start = cfg.h_res + cfg.h_fp;
    hs_end   = hs_start + cfg.h_sp;
    vs_start = cfg.v_res + cfg.v_fp;
    vs_end   = vs_start + cfg.v_sp;
    gate     = vid.enable & run_q;
    visible  = (x_q < cfg.h_res) && (y_q < cfg.v_res);
    h_act    = (x_q >= hs_start) && (x_q < hs_end);
    v_act    = (y_q >= vs_start) && (y_q < vs_end);
    sample_c = {(gate & h_act) ~^ cfg.pos_pol,
                (gate & v_act) ~^ cfg.pos_pol,
                ~(gate & visible)};
  end

  localparam logic RST_INACT = ~MODE_TABLE[C_default_mode].pos_pol;
  localparam logic [SYNC_W-1:0] SYNC_RST = {RST_INACT, RST_INACT, 1'b1};

  sync_delay_line #(
    .WIDTH (SYNC_W),
    .DEPTH (C_delay)
  ) u_delay (
    .clk       (clk_pixel),
    .rst_n     (resetn),
    .rst_value (SYNC_RST),
    .d         (sample_c),
    .q         (delayed)
  );

  assign vid.mode_cur    = mode_q;
  assign vid.beam_x      = x_q;
  assign vid.beam_y      = y_q;
  assign vid.frame_start = fs_q;
  assign vid.vga_hsync   = delayed[2];
  assign vid.vga_vsync   = delayed[1];
  assign vid.vga_blank   = delayed[0];

endmodule

// File: tb/tb_video_timing_multi.sv
// Randomised scoreboard bench for video_timing_multi. The reference model
// tracks the beam as a linear pixel index within the frame.
module tb_video_timing_multi;

  localparam int unsigned TB_DELAY = 3;
  localparam int DEF_MODE = 2;

  localparam int HRES [4] = '{640, 1280, 1920, 800};
  localparam int HFP  [4] = '{16, 110, 88, 40};
  localparam int HSP  [4] = '{96, 40, 44, 128};
  localparam int HBP  [4] = '{48, 220, 148, 88};
  localparam int VRES [4] = '{480, 720, 1080, 600};
  localparam int VFP  [4] = '{10, 5, 4, 1};
  localparam int VSP  [4] = '{2, 5, 5, 4};
  localparam int VBP  [4] = '{33, 20, 36, 23};
  localparam int POS  [4] = '{0, 1, 1, 1};

  typedef struct packed {
    logic [1:0]  mode;
    logic [11:0] x;
    logic [10:0] y;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        blank;
  } obs_t;

  logic clk;
  logic resetn;

  video_timing_multi_if vif ();

  video_timing_multi #(
    .C_delay        (TB_DELAY),
    .C_default_mode (2'(DEF_MODE))
  ) dut (
    .clk_pixel (clk),
    .resetn    (resetn),
    .vid       (vif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_pos;
  int         m_mode;
  bit         m_started;
  bit         m_fs;
  logic [2:0] m_hist [$];
  obs_t       exp_q [$];

  function automatic int ht(input int m);
    return HRES[m] + HFP[m] + HSP[m] + HBP[m];
  endfunction

  function automatic int vt(input int m);
    return VRES[m] + VFP[m] + VSP[m] + VBP[m];
  endfunction

  // {hsync, vsync, blank} for the beam currently presented
  function automatic logic [2:0] model_sample();
    int  x, y;
    bit  ha, va, vis;
    logic pol;
    pol = 1'(POS[m_mode]);
    if (!(vif.enable && m_started)) return {~pol, ~pol, 1'b1};
    x   = m_pos % ht(m_mode);
    y   = m_pos / ht(m_mode);
    vis = (x < HRES[m_mode]) && (y < VRES[m_mode]);
    ha  = (x >= HRES[m_mode] + HFP[m_mode]) && (x < HRES[m_mode] + HFP[m_mode] + HSP[m_mode]);
    va  = (y >= VRES[m_mode] + VFP[m_mode]) && (y < VRES[m_mode] + VFP[m_mode] + VSP[m_mode]);
    return {ha ? pol : ~pol, va ? pol : ~pol, ~vis};
  endfunction

  function automatic void model_reset();
    logic pol;
    pol       = 1'(POS[DEF_MODE]);
    m_pos     = 0;
    m_mode    = DEF_MODE;
    m_started = 0;
    m_fs      = 0;
    m_hist.delete();
    for (int i = 0; i < int'(TB_DELAY); i++) m_hist.push_back({~pol, ~pol, 1'b1});
  endfunction

  // One rising edge with the inputs that were applied before it
  function automatic void model_edge();
    if (!resetn) return;
    m_hist.push_back(model_sample());
    void'(m_hist.pop_front());
    if (!vif.enable) begin
      m_pos = 0; m_started = 0; m_fs = 0; m_mode = int'(vif.mode_sel);
    end else if (!m_started) begin
      m_pos = 0; m_started = 1; m_fs = 1;
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == ht(m_mode) * vt(m_mode)) begin
        m_pos  = 0;
        m_mode = int'(vif.mode_sel);
      end
      m_fs = (m_pos == 0);
    end
  endfunction

  function automatic obs_t expect_now();
    obs_t e;
    e.mode = 2'(m_mode);
    e.x    = 12'(m_pos % ht(m_mode));
    e.y    = 11'(m_pos / ht(m_mode));
    e.fs   = m_fs;
    if (TB_DELAY == 0) {e.hs, e.vs, e.blank} = model_sample();
    else               {e.hs, e.vs, e.blank} = m_hist[0];
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.mode  = vif.mode_cur;
    a.x     = vif.beam_x;
    a.y     = vif.beam_y;
    a.fs    = vif.frame_start;
    a.hs    = vif.vga_hsync;
    a.vs    = vif.vga_vsync;
    a.blank = vif.vga_blank;
    return a;
  endfunction

  task automatic check_obs(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got mode=%0d x=%0d y=%0d fs=%0b hs=%0b vs=%0b blank=%0b, want mode=%0d x=%0d y=%0d fs=%0b hs=%0b vs=%0b blank=%0b",
               name, $time, a.mode, a.x, a.y, a.fs, a.hs, a.vs, a.blank,
               e.mode, e.x, e.y, e.fs, e.hs, e.vs, e.blank);
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_obs("cycle", observe(), exp_q.pop_front());
  end

  // Advance one clock, then apply new inputs and queue the expectation
  task automatic step(input logic en, input logic [1:0] ms);
    @(posedge clk);
    #1;
    model_edge();
    vif.enable   = en;
    vif.mode_sel = ms;
    exp_q.push_back(expect_now());
    #6;
  endtask

  // Enabled cycles with a freshly randomised (ignored mid-frame) mode_sel
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'($urandom_range(0, 3)));
  endtask

  task automatic hold(input int n, input logic [1:0] ms);
    for (int i = 0; i < n; i++) step(1'b0, ms);
  endtask

  // Asynchronous reset between edges; outputs must react without a clock
  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_obs("async_reset", observe(), expect_now());
    step(1'b1, 2'($urandom_range(0, 3)));
    step(1'b1, 2'($urandom_range(0, 3)));
    resetn = 1'b1;
  endtask

  initial begin
    vif.enable   = 1'b0;
    vif.mode_sel = 2'd2;
    resetn       = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    model_reset();
    check_obs("reset_state", observe(), expect_now());
    step(1'b1, 2'd2);
    step(1'b1, 2'd2);
    resetn = 1'b1;

    // Mode 2 from reset: three lines with random mode_sel noise
    run_cycles(6700);

    // Switch to mode 0 through an enable hold, three lines
    hold(5, 2'd0);
    run_cycles(2500);

    // Back to mode 2, drop enable at x=1000 for 10 clocks
    hold(3, 2'd2);
    run_cycles(1001);
    hold(10, 2'd2);
    run_cycles(300);

    // Reset mid-line
    run_cycles(1500);
    pulse_reset();
    run_cycles(500);

    // Random segments across all modes
    for (int s = 0; s < 12; s++) begin
      hold($urandom_range(1, 12), 2'($urandom_range(0, 3)));
      run_cycles($urandom_range(300, 2500));
      if ($urandom_range(0, 3) == 0) begin
        pulse_reset();
        run_cycles($urandom_range(100, 600));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
